// File: rtl/es_ordered_nmul_acc_pkg.sv
// Shared types and width helper for the deterministic stochastic-computing N-input unit.
// The file name follows the block; the package is dsc_pkg.
package dsc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dsc_state_t;

    typedef enum logic {
        MODE_AND = 1'b0,
        MODE_OR  = 1'b1
    } dsc_mode_t;

    // Result width: one W-bit digit per operand, so the counter spans every digit combination.
    function automatic int dsc_out_width(input int data_width, input int num_inputs);
        return data_width * num_inputs;
    endfunction

endpackage

// File: rtl/es_ordered_nmul_acc_if.sv
// Handshake and operand bus of the DSC N-input arithmetic unit.
interface es_ordered_nmul_acc_if #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_INPUTS = 2
);
    import dsc_pkg::*;

    localparam int OUT_WIDTH = dsc_out_width(DATA_WIDTH, NUM_INPUTS);

    logic                  en;
    logic                  start;
    dsc_mode_t             mode;
    logic [DATA_WIDTH-1:0] bin_data_in [NUM_INPUTS];
    logic [OUT_WIDTH-1:0]  bin_data_out;
    logic                  busy;
    logic                  done;

    modport master (
        output en,
        output start,
        output mode,
        output bin_data_in,
        input  bin_data_out,
        input  busy,
        input  done
    );

    modport slave (
        input  en,
        input  start,
        input  mode,
        input  bin_data_in,
        output bin_data_out,
        output busy,
        output done
    );

endinterface

// File: rtl/es_ordered_nmul_acc_sng.sv
// Unary stream generator: one operand's stream bit for the current digit of the shared counter.
module dsc_unary_sng #(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] digit,
    input  logic [DATA_WIDTH-1:0] x,
    output logic                  stream_bit
);

    // Over one full digit period, exactly x of the 2^W digit values lie below x.
    assign stream_bit = (digit < x);

endmodule

// File: rtl/es_ordered_nmul_acc.sv
// DSC N-input multiplier/complementary adder: clock-divided unary streams, AND/OR combine, ones count.
module es_ordered_nmul_acc
    import dsc_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_INPUTS = 2
) (
    input logic                  clk,
    input logic                  rst,
    es_ordered_nmul_acc_if.slave bus
);

    localparam int OUT_WIDTH = dsc_out_width(DATA_WIDTH, NUM_INPUTS);

    dsc_state_t            state;
    dsc_state_t            state_n;
    dsc_mode_t             mode_q;
    logic [DATA_WIDTH-1:0] x_q [NUM_INPUTS];
    logic [OUT_WIDTH-1:0]  cnt;
    logic [OUT_WIDTH-1:0]  acc;
    logic [OUT_WIDTH-1:0]  result;
    logic [OUT_WIDTH-1:0]  comb_ext;
    logic [NUM_INPUTS-1:0] stream;
    logic                  comb;
    logic                  cnt_last;
    logic                  any_zero;
    logic                  load;
    logic                  short_zero;
    logic                  finish;

    // Counter digit i drives operand i; digit 0 is the fastest-changing one.
    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_sng
        dsc_unary_sng #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_sng (
            .digit     (cnt[g*DATA_WIDTH +: DATA_WIDTH]),
            .x         (x_q[g]),
            .stream_bit(stream[g])
        );
    end

    assign comb     = (mode_q == MODE_AND) ? (&stream) : (|stream);
    assign comb_ext = {{(OUT_WIDTH-1){1'b0}}, comb};
    assign cnt_last = (cnt == {OUT_WIDTH{1'b1}});

    always_comb begin
        any_zero = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (bus.bin_data_in[i] == '0) begin
                any_zero = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else if (bus.en) begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        load       = 1'b0;
        short_zero = 1'b0;
        finish     = 1'b0;
        if (bus.en) begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        load = 1'b1;
                        // A zero operand makes the product zero, so no stream pass is needed.
                        if ((bus.mode == MODE_AND) && any_zero) begin
                            short_zero = 1'b1;
                            state_n    = DONE;
                        end else begin
                            state_n = RUN;
                        end
                    end
                end
                RUN: begin
                    if (cnt_last) begin
                        finish  = 1'b1;
                        state_n = DONE;
                    end
                end
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= MODE_AND;
            cnt    <= '0;
            acc    <= '0;
            result <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                x_q[i] <= '0;
            end
        end else if (bus.en) begin
            if (load) begin
                mode_q <= bus.mode;
                cnt    <= '0;
                acc    <= '0;
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    x_q[i] <= bus.bin_data_in[i];
                end
            end
            if (short_zero) begin
                result <= '0;
            end
            if (state == RUN) begin
                // The final cycle's stream bit is folded in directly instead of costing an extra cycle.
                if (finish) begin
                    result <= acc + comb_ext;
                    cnt    <= '0;
                    acc    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                    acc <= acc + comb_ext;
                end
            end
        end
    end

    assign bus.busy         = (state == RUN);
    assign bus.done         = (state == DONE);
    assign bus.bin_data_out = result;

endmodule
